// File: rtl/fl_checkpoint_ctrl_pkg.sv
// Shared types and sizing for the free-list branch checkpoint controller.
// Sizing matches NUM_GEN_REG=32 / NUM_PHYS_REG=64.
package fl_checkpoint_ctrl_pkg;

    localparam int unsigned NumPhysReg = 64;
    localparam int unsigned PhysRegW   = $clog2(NumPhysReg);
    localparam int unsigned FlSize     = NumPhysReg;
    localparam int unsigned TlW        = $clog2(FlSize) + 1;
    localparam int unsigned ListW      = FlSize * PhysRegW;
    localparam int unsigned NumCkpt    = 4;
    localparam int unsigned TagW       = $clog2(NumCkpt);

    typedef logic [PhysRegW-1:0] phys_reg_t;
    typedef logic [TagW-1:0]     ckpt_tag_t;

    typedef struct packed {
        logic [ListW-1:0] list;
        logic [TlW-1:0]   tail;
    } fl_snapshot_t;

    typedef enum logic [0:0] {StIdle, StRecover} ckpt_state_e;

    // Circular distance from 'from' forward to 'to'; relies on NumCkpt being a power of 2.
    function automatic ckpt_tag_t tag_dist(ckpt_tag_t from, ckpt_tag_t to);
        return to - from;
    endfunction

endpackage

// File: rtl/fl_checkpoint_ctrl_snapshot_apply.sv
// Combinational free-list update of one snapshot: optional pop (shift down) then optional push.
// Mirrors the free list's own next-state so snapshots stay bit-identical to it.
module fl_checkpoint_ctrl_snapshot_apply
    import fl_checkpoint_ctrl_pkg::*;
(
    input  logic [ListW-1:0]    list_i,
    input  logic [TlW-1:0]      tail_i,
    input  logic                pop_i,
    input  logic                push_i,
    input  logic [PhysRegW-1:0] push_reg_i,
    output logic [ListW-1:0]    list_o,
    output logic [TlW-1:0]      tail_o
);

    logic [ListW-1:0] list_mid;
    logic [TlW-1:0]   tail_mid;

    always_comb begin
        list_mid = list_i;
        tail_mid = tail_i;
        if (pop_i && (tail_i != '0)) begin
            list_mid = {{PhysRegW{1'b0}}, list_i[ListW-1:PhysRegW]};
            tail_mid = tail_i - TlW'(1);
        end
        list_o = list_mid;
        tail_o = tail_mid;
        if (push_i && (tail_mid != TlW'(FlSize))) begin
            list_o[int'(tail_mid[TlW-2:0]) * int'(PhysRegW) +: PhysRegW] = push_reg_i;
            tail_o = tail_mid + TlW'(1);
        end
    end

endmodule

// File: rtl/fl_checkpoint_ctrl.sv
// Branch checkpoint controller for the physical-register free list.
// Optional FL_CKPT_DEBUG_EN adds slot-valid and mispredict-count debug outputs.
module fl_checkpoint_ctrl
    import fl_checkpoint_ctrl_pkg::*;
(
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic [ListW-1:0]    fl_free_list_i,
    input  logic [TlW-1:0]      fl_tail_i,
    input  logic                dispatch_en_i,
    input  logic                retire_en_i,
    input  logic [PhysRegW-1:0] retire_t_old_i,
    input  logic                branch_dispatch_i,
    input  logic                resolve_en_i,
    input  logic [TagW-1:0]     resolve_tag_i,
    input  logic                resolve_correct_i,
    output logic [TagW-1:0]     ckpt_tag_o,
    output logic                ckpt_full_o,
    output logic                branch_incorrect_o,
    output logic [ListW-1:0]    free_check_point_o,
    output logic [TlW-1:0]      tail_check_point_o
`ifdef FL_CKPT_DEBUG_EN
    ,
    output logic [NumCkpt-1:0]  ckpt_valid_out_o,
    output logic [15:0]         mispredict_cnt_o
`endif
);

    ckpt_state_e        state_q, state_d;
    logic [NumCkpt-1:0] slot_valid_q, slot_valid_d;
    ckpt_tag_t          alloc_q, alloc_d;
    fl_snapshot_t       restore_q, restore_d;
    fl_snapshot_t       slot_q [NumCkpt];
    fl_snapshot_t       slot_d [NumCkpt];
    logic [ListW-1:0]   slot_list_upd [NumCkpt];
    logic [TlW-1:0]     slot_tail_upd [NumCkpt];
    fl_snapshot_t       capture;
    fl_snapshot_t       restore_upd;

    logic accept_dispatch, resolve_ok, mispredict;

    fl_checkpoint_ctrl_snapshot_apply u_capture (
        .list_i     (fl_free_list_i),
        .tail_i     (fl_tail_i),
        .pop_i      (dispatch_en_i),
        .push_i     (retire_en_i),
        .push_reg_i (retire_t_old_i),
        .list_o     (capture.list),
        .tail_o     (capture.tail)
    );

    // Live slots only ever see pushes: any pop after the branch belongs to a younger, squashable op.
    for (genvar g = 0; g < NumCkpt; g++) begin : g_slot
        fl_checkpoint_ctrl_snapshot_apply u_apply (
            .list_i     (slot_q[g].list),
            .tail_i     (slot_q[g].tail),
            .pop_i      (1'b0),
            .push_i     (retire_en_i),
            .push_reg_i (retire_t_old_i),
            .list_o     (slot_list_upd[g]),
            .tail_o     (slot_tail_upd[g])
        );
    end

    fl_checkpoint_ctrl_snapshot_apply u_restore (
        .list_i     (restore_q.list),
        .tail_i     (restore_q.tail),
        .pop_i      (1'b0),
        .push_i     (retire_en_i),
        .push_reg_i (retire_t_old_i),
        .list_o     (restore_upd.list),
        .tail_o     (restore_upd.tail)
    );

    assign resolve_ok      = resolve_en_i && (state_q == StIdle) && slot_valid_q[resolve_tag_i];
    assign mispredict      = resolve_ok && !resolve_correct_i;
    assign accept_dispatch = branch_dispatch_i && (state_q == StIdle) && !slot_valid_q[alloc_q];

    always_comb begin
        slot_valid_d = slot_valid_q;
        alloc_d      = alloc_q;
        restore_d    = restore_q;
        for (int i = 0; i < NumCkpt; i++) begin
            slot_d[i] = '{list: slot_list_upd[i], tail: slot_tail_upd[i]};
        end
        if (mispredict) begin
            restore_d = '{list: slot_list_upd[resolve_tag_i], tail: slot_tail_upd[resolve_tag_i]};
            for (int i = 0; i < NumCkpt; i++) begin
                // Zero distance to alloc means the ring is full, so everything is younger.
                if ((tag_dist(resolve_tag_i, alloc_q) == '0) ||
                    (tag_dist(resolve_tag_i, ckpt_tag_t'(i)) < tag_dist(resolve_tag_i, alloc_q))) begin
                    slot_valid_d[i] = 1'b0;
                end
            end
            alloc_d = resolve_tag_i;
        end else begin
            if (resolve_ok) begin
                slot_valid_d[resolve_tag_i] = 1'b0;
            end
            if (accept_dispatch) begin
                slot_valid_d[alloc_q] = 1'b1;
                slot_d[alloc_q]       = capture;
                alloc_d               = alloc_q + ckpt_tag_t'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (mispredict) state_d = StRecover;
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            slot_valid_q <= '0;
            alloc_q      <= '0;
            restore_q    <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            alloc_q      <= alloc_d;
            restore_q    <= restore_d;
        end
    end

    always_ff @(posedge clock_i) begin
        for (int i = 0; i < NumCkpt; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        ckpt_tag_o         = alloc_q;
        ckpt_full_o        = slot_valid_q[alloc_q] || (state_q == StRecover);
        branch_incorrect_o = (state_q == StRecover);
        free_check_point_o = restore_q.list;
        tail_check_point_o = restore_q.tail;
        if (state_q == StRecover) begin
            free_check_point_o = restore_upd.list;
            tail_check_point_o = restore_upd.tail;
        end
    end

`ifdef FL_CKPT_DEBUG_EN
    logic [15:0] mispredict_cnt_q;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            mispredict_cnt_q <= '0;
        end else if (mispredict && (mispredict_cnt_q != 16'hffff)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end

    assign ckpt_valid_out_o = slot_valid_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Directed self-checking bench for fl_checkpoint_ctrl (default build, debug ports absent).
module tb_fl_checkpoint_ctrl;
    import fl_checkpoint_ctrl_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [ListW-1:0]    fl_free_list;
    logic [TlW-1:0]      fl_tail;
    logic                dispatch_en, retire_en, branch_dispatch;
    logic                resolve_en, resolve_correct;
    logic [PhysRegW-1:0] retire_t_old;
    logic [TagW-1:0]     resolve_tag;
    logic [TagW-1:0]     ckpt_tag;
    logic                ckpt_full, branch_incorrect;
    logic [ListW-1:0]    fcp;
    logic [TlW-1:0]      tcp;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fl_checkpoint_ctrl u_dut (
        .clock_i            (clock),
        .reset_n_i          (reset_n),
        .fl_free_list_i     (fl_free_list),
        .fl_tail_i          (fl_tail),
        .dispatch_en_i      (dispatch_en),
        .retire_en_i        (retire_en),
        .retire_t_old_i     (retire_t_old),
        .branch_dispatch_i  (branch_dispatch),
        .resolve_en_i       (resolve_en),
        .resolve_tag_i      (resolve_tag),
        .resolve_correct_i  (resolve_correct),
        .ckpt_tag_o         (ckpt_tag),
        .ckpt_full_o        (ckpt_full),
        .branch_incorrect_o (branch_incorrect),
        .free_check_point_o (fcp),
        .tail_check_point_o (tcp)
    );

    function automatic int ent(int i);
        return int'(fcp[i*PhysRegW +: PhysRegW]);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_en = 0; retire_en = 0; retire_t_old = '0; branch_dispatch = 0;
        resolve_en = 0; resolve_tag = '0; resolve_correct = 0;
    endtask

    // Free list holds pr(32+k) at position k below the tail, zero above it.
    task automatic load_fl(input int t);
        fl_free_list = '0;
        for (int k = 0; k < t; k++) fl_free_list[k*PhysRegW +: PhysRegW] = PhysRegW'(32 + k);
        fl_tail = TlW'(t);
    endtask

    task automatic do_reset();
        idle_inputs();
        load_fl(32);
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic mispredict(input int tag);
        resolve_en = 1; resolve_tag = TagW'(tag); resolve_correct = 0;
        tick();
        resolve_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ckpt_tag !== 0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", ckpt_tag); end
        total++; if (ckpt_full !== 0) begin bad++; $display("FAIL reset_full got=%0d exp=0", ckpt_full); end
        total++; if (branch_incorrect !== 0) begin bad++; $display("FAIL reset_bi got=%0d exp=0", branch_incorrect); end
        total++; if (tcp !== 0 || fcp !== '0) begin bad++; $display("FAIL reset_restore tail=%0d exp=0", tcp); end
        branch_dispatch = 1;
        total++; if (ckpt_tag !== 0) begin bad++; $display("FAIL t1_tag got=%0d exp=0", ckpt_tag); end
        tick();
        branch_dispatch = 0;
        total++; if (ckpt_tag !== 1) begin bad++; $display("FAIL t1_alloc got=%0d exp=1", ckpt_tag); end
        total++; if (branch_incorrect !== 0) begin bad++; $display("FAIL t1_bi_early got=%0d exp=0", branch_incorrect); end
        mispredict(0);
        total++; if (branch_incorrect !== 1) begin bad++; $display("FAIL t1_bi got=%0d exp=1", branch_incorrect); end
        total++; if (ent(0) !== 32) begin bad++; $display("FAIL t1_entry0 got=%0d exp=32", ent(0)); end
        total++; if (tcp !== 32) begin bad++; $display("FAIL t1_tail got=%0d exp=32", tcp); end
        total++; if (ckpt_full !== 1 || ckpt_tag !== 0) begin bad++; $display("FAIL t1_recover_full got=%0d/%0d exp=1/0", ckpt_full, ckpt_tag); end
        tick();
        total++; if (branch_incorrect !== 0) begin bad++; $display("FAIL t1_bi_pulse got=%0d exp=0", branch_incorrect); end
        total++; if (ckpt_full !== 0) begin bad++; $display("FAIL t1_idle_full got=%0d exp=0", ckpt_full); end
    endtask

    task automatic test_retire_tracking();
        do_reset();
        branch_dispatch = 1; tick(); branch_dispatch = 0;
        retire_en = 1; retire_t_old = 6'd5; tick(); retire_en = 0;
        mispredict(0);
        total++; if (tcp !== 33) begin bad++; $display("FAIL t2_tail got=%0d exp=33", tcp); end
        total++; if (ent(32) !== 5) begin bad++; $display("FAIL t2_entry32 got=%0d exp=5", ent(32)); end
        total++; if (ent(0) !== 32) begin bad++; $display("FAIL t2_entry0 got=%0d exp=32", ent(0)); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            branch_dispatch = 1;
            total++; if (ckpt_tag !== TagW'(i)) begin bad++; $display("FAIL t3_tag%0d got=%0d exp=%0d", i, ckpt_tag, i); end
            tick();
        end
        total++; if (ckpt_full !== 1) begin bad++; $display("FAIL t3_full got=%0d exp=1", ckpt_full); end
        tick();
        branch_dispatch = 0;
        total++; if (ckpt_tag !== 0 || ckpt_full !== 1) begin bad++; $display("FAIL t3_fifth got=%0d/%0d exp=0/1", ckpt_tag, ckpt_full); end
        resolve_en = 1; resolve_correct = 1; resolve_tag = 2'd1; tick();
        total++; if (ckpt_full !== 1) begin bad++; $display("FAIL t3_res1_full got=%0d exp=1", ckpt_full); end
        resolve_tag = 2'd0; tick(); resolve_en = 0;
        total++; if (ckpt_full !== 0 || ckpt_tag !== 0) begin bad++; $display("FAIL t3_res0 got=%0d/%0d exp=0/0", ckpt_full, ckpt_tag); end
        total++; if (branch_incorrect !== 0) begin bad++; $display("FAIL t3_bi got=%0d exp=0", branch_incorrect); end
    endtask

    task automatic test_squash();
        do_reset();
        branch_dispatch = 1; tick(); tick(); tick(); branch_dispatch = 0;
        mispredict(1);
        total++; if (ckpt_tag !== 1 || branch_incorrect !== 1) begin bad++; $display("FAIL t4_recover got=%0d/%0d exp=1/1", ckpt_tag, branch_incorrect); end
        tick();
        total++; if (ckpt_full !== 0) begin bad++; $display("FAIL t4_full got=%0d exp=0", ckpt_full); end
        // Slots 1,2 were squashed so they reallocate; slot 0 still live stops the ring at tag 0.
        branch_dispatch = 1;
        for (int i = 1; i < 4; i++) begin
            total++; if (ckpt_tag !== TagW'(i) || ckpt_full !== 0) begin bad++; $display("FAIL t4_realloc%0d got=%0d/%0d exp=%0d/0", i, ckpt_tag, ckpt_full, i); end
            tick();
        end
        branch_dispatch = 0;
        total++; if (ckpt_tag !== 0 || ckpt_full !== 1) begin bad++; $display("FAIL t4_slot0 got=%0d/%0d exp=0/1", ckpt_tag, ckpt_full); end
    endtask

    task automatic test_recover_retire();
        do_reset();
        load_fl(30);
        branch_dispatch = 1; tick(); branch_dispatch = 0;
        mispredict(0);
        retire_en = 1; retire_t_old = 6'd7; #1;
        total++; if (tcp !== 31) begin bad++; $display("FAIL t5_tail got=%0d exp=31", tcp); end
        total++; if (ent(30) !== 7) begin bad++; $display("FAIL t5_entry30 got=%0d exp=7", ent(30)); end
        total++; if (ent(29) !== 61) begin bad++; $display("FAIL t5_entry29 got=%0d exp=61", ent(29)); end
        retire_en = 0; #1;
        total++; if (tcp !== 30) begin bad++; $display("FAIL t5_noretire got=%0d exp=30", tcp); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        branch_dispatch = 1; dispatch_en = 1; retire_en = 1; retire_t_old = 6'd9;
        tick();
        idle_inputs();
        mispredict(0);
        total++; if (tcp !== 32) begin bad++; $display("FAIL t6_tail got=%0d exp=32", tcp); end
        total++; if (ent(0) !== 33) begin bad++; $display("FAIL t6_head got=%0d exp=33", ent(0)); end
        total++; if (ent(31) !== 9) begin bad++; $display("FAIL t6_entry31 got=%0d exp=9", ent(31)); end
        total++; if (ent(30) !== 63) begin bad++; $display("FAIL t6_entry30 got=%0d exp=63", ent(30)); end
        reset_n = 0; tick(); reset_n = 1;
        total++; if (branch_incorrect !== 0 || ckpt_full !== 0) begin bad++; $display("FAIL t6_reset got=%0d/%0d exp=0/0", branch_incorrect, ckpt_full); end
        for (int i = 0; i < 4; i++) begin
            mispredict(i);
            total++; if (branch_incorrect !== 0) begin bad++; $display("FAIL t6_slot%0d_invalid got=%0d exp=0", i, branch_incorrect); end
        end
    endtask

    task automatic test_bounds();
        do_reset();
        load_fl(0);
        branch_dispatch = 1; dispatch_en = 1; tick(); idle_inputs();
        mispredict(0);
        total++; if (tcp !== 0) begin bad++; $display("FAIL b_empty_pop got=%0d exp=0", tcp); end
        tick();
        load_fl(64);
        branch_dispatch = 1; retire_en = 1; retire_t_old = 6'd3; tick(); idle_inputs();
        mispredict(0);
        total++; if (tcp !== 64 || ent(63) !== 31) begin bad++; $display("FAIL b_full_push got=%0d/%0d exp=64/31", tcp, ent(63)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_retire_tracking();
        test_full();
        test_squash();
        test_recover_retire();
        test_back_to_back();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
